// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply-divide unit.
interface mips_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, div_zero, HI, LO
  );
endinterface

// File: rtl/mips_muldiv.sv
// MIPS HI/LO unit: 32-iteration shift-add multiply and restoring divide,
// plus single-cycle MTHI/MTLO writes. Results reach HI/LO only on completion.
module mips_muldiv (
  input  logic        clk,
  input  logic        reset,
  mips_muldiv_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_is_div;   // latched op class: 1 = divide, 0 = multiply
  logic        r_neg;      // negate product / quotient at the end
  logic        r_rem_neg;  // remainder takes the dividend's sign
  logic        r_dz;       // divide by zero: skip iterations, report next edge
  logic [31:0] r_bm;       // magnitude of B (multiplicand or divisor)
  logic [31:0] r_wacc;     // upper working half: partial product / remainder
  logic [31:0] r_wlo;      // lower working half: multiplier bits / quotient
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic        r_div_zero;

  // Operand preparation at acceptance time
  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  // One iteration of the active algorithm
  logic [32:0] w_msum;
  logic [31:0] w_mul_acc_next;
  logic [31:0] w_mul_lo_next;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_dsub;
  logic [31:0] w_div_acc_next;
  logic [31:0] w_div_lo_next;
  logic [31:0] w_acc_next;
  logic [31:0] w_lo_next;

  // Sign-corrected final results
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // Signed ops take magnitudes; signs are reapplied once the loop finishes
  always_comb begin
    w_signed = ~bus.op[0];
    w_a_mag  = (w_signed && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
    w_b_mag  = (w_signed && bus.B[31]) ? (32'd0 - bus.B) : bus.B;
  end

  // Iteration datapath: shift-add multiply or restoring divide step
  always_comb begin
    // Multiply: add multiplicand when the current multiplier LSB is set,
    // then shift the 64-bit {acc, lo} pair right by one.
    w_msum         = {1'b0, r_wacc} + (r_wlo[0] ? {1'b0, r_bm} : 33'd0);
    w_mul_acc_next = w_msum[32:1];
    w_mul_lo_next  = {w_msum[0], r_wlo[31:1]};

    // Divide: shift the next dividend bit into the remainder and subtract
    // when it fits. When it fits the true difference is below 2^32, so a
    // 32-bit subtraction is exact.
    w_shift        = {r_wacc, r_wlo[31]};
    w_ge           = (w_shift >= {1'b0, r_bm});
    w_dsub         = w_shift[31:0] - r_bm;
    w_div_acc_next = w_ge ? w_dsub : w_shift[31:0];
    w_div_lo_next  = {r_wlo[30:0], w_ge};

    w_acc_next = r_is_div ? w_div_acc_next : w_mul_acc_next;
    w_lo_next  = r_is_div ? w_div_lo_next  : w_mul_lo_next;

    w_prod     = {w_acc_next, w_lo_next};
    w_prod_fix = r_neg ? (64'd0 - w_prod) : w_prod;
    w_q_fix    = r_neg ? (32'd0 - w_lo_next) : w_lo_next;
    w_r_fix    = r_rem_neg ? (32'd0 - w_acc_next) : w_acc_next;
  end

  // Control FSM with registered status outputs and HI/LO ownership
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_is_div   <= 1'b0;
      r_neg      <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_dz       <= 1'b0;
      r_bm       <= 32'd0;
      r_wacc     <= 32'd0;
      r_wlo      <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          // DONE lasts one cycle; both states accept a new request
          r_state <= S_IDLE;
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: r_hi <= bus.A;
              OP_MTLO: r_lo <= bus.A;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_is_div  <= bus.op[1];
                r_neg     <= w_signed & (bus.A[31] ^ bus.B[31]);
                r_rem_neg <= w_signed & bus.A[31];
                r_dz      <= bus.op[1] & (bus.B == 32'd0);
                r_bm      <= w_b_mag;
                r_wacc    <= 32'd0;
                r_wlo     <= w_a_mag;
                r_cnt     <= 5'd0;
                r_busy    <= 1'b1;
                r_state   <= S_RUN;
              end
              default: ; // reserved opcodes are ignored
            endcase
          end
        end
        S_RUN: begin
          if (r_dz) begin
            // Divide by zero: report immediately, leave HI/LO untouched
            r_dz       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_wacc <= w_acc_next;
            r_wlo  <= w_lo_next;
            r_cnt  <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              if (r_is_div) begin
                r_hi <= w_r_fix;
                r_lo <= w_q_fix;
              end else begin
                r_hi <= w_prod_fix[63:32];
                r_lo <= w_prod_fix[31:0];
              end
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed, table-driven bench for mips_muldiv with hand-computed results.
module tb_mips_muldiv;

  logic clk = 1'b0;
  logic reset;

  mips_muldiv_if bus();

  mips_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request for one edge (E0), then scramble operands so that
  // anything sampled after E0 would be visibly wrong.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Wait for done with a bounded cycle budget; HI/LO must hold mid-run.
  task automatic wait_done(output int n, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    bit seen;
    int i;
    seen = 1'b0;
    n    = 0;
    i    = 0;
    while (!seen && i < 40) begin
      i++;
      @(posedge clk);
      #1;
      if (i == 16) begin
        chk("hold_hi_midrun", bus.HI, hold_hi);
        chk("hold_lo_midrun", bus.LO, hold_lo);
      end
      if (bus.done) begin
        seen = 1'b1;
        n    = i;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done in 40 cycles, required done");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int done_seen;
    logic [31:0] hi0, lo0;

    vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'b000, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[8]  = '{3'b000, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC};
    vecs[9]  = '{3'b010, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
    vecs[10] = '{3'b011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[11] = '{3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[12] = '{3'b011, 32'h00000003, 32'h00000010, 32'h00000003, 32'h00000000};
    vecs[13] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_dz", bus.div_zero, 0);
    chk("reset_hi", bus.HI, 0);
    chk("reset_lo", bus.LO, 0);
    @(negedge clk);
    reset = 1'b0;

    // Table: odd entries leave idle gaps; even entries chain straight into
    // the next start during the DONE cycle.
    for (int i = 0; i < 14; i++) begin
      hi0 = bus.HI;
      lo0 = bus.LO;
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      chk("busy_at_e0", bus.busy, 1);
      wait_done(n, hi0, lo0);
      chk("done_latency", n, 32);
      chk("result_hi", bus.HI, vecs[i].hi);
      chk("result_lo", bus.LO, vecs[i].lo);
      chk("dz_clear", bus.div_zero, 0);
      chk("busy_at_done", bus.busy, 0);
      $display("vec %0d op=%0d A=%h B=%h -> HI=%h LO=%h lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.HI, bus.LO, n);
      if (i % 2 == 1) begin
        @(posedge clk);
        #1;
        chk("done_one_cycle", bus.done, 0);
        @(posedge clk);
      end
    end

    // MTHI / MTLO then divide by zero
    start_op(3'b100, 32'h12345678, 32'h0);
    chk("mthi_hi", bus.HI, 32'h12345678);
    chk("mthi_busy", bus.busy, 0);
    chk("mthi_done", bus.done, 0);
    start_op(3'b101, 32'hCAFEF00D, 32'h0);
    chk("mtlo_lo", bus.LO, 32'hCAFEF00D);
    start_op(3'b011, 32'h00000007, 32'h00000000);
    chk("dz_busy_e0", bus.busy, 1);
    chk("dz_no_done_e0", bus.done, 0);
    @(posedge clk);
    #1;
    chk("dz_done", bus.done, 1);
    chk("dz_flag", bus.div_zero, 1);
    chk("dz_busy_off", bus.busy, 0);
    chk("dz_hi_kept", bus.HI, 32'h12345678);
    chk("dz_lo_kept", bus.LO, 32'hCAFEF00D);
    $display("divu by zero -> done=%0d div_zero=%0d HI=%h LO=%h", bus.done, bus.div_zero, bus.HI, bus.LO);
    @(posedge clk);
    #1;
    chk("dz_done_pulse", bus.done, 0);
    chk("dz_flag_pulse", bus.div_zero, 0);

    // Reserved opcode is ignored
    start_op(3'b110, 32'hDEADBEEF, 32'h1);
    chk("rsvd_busy", bus.busy, 0);
    chk("rsvd_hi", bus.HI, 32'h12345678);
    chk("rsvd_lo", bus.LO, 32'hCAFEF00D);
    $display("reserved op 110 -> busy=%0d HI=%h LO=%h", bus.busy, bus.HI, bus.LO);

    // MULTU aborted by reset; a start while busy must be dropped
    start_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.A     = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("busy_start_hi", bus.HI, 32'h12345678);
    chk("busy_still_run", bus.busy, 1);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_hi", bus.HI, 0);
    chk("abort_lo", bus.LO, 0);
    chk("abort_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_hi_after", bus.HI, 0);
    $display("reset abort -> busy=%0d HI=%h LO=%h done_seen=%0d", bus.busy, bus.HI, bus.LO, done_seen);

    // First request after reset is accepted normally
    start_op(3'b011, 32'h00000007, 32'h00000002);
    chk("post_reset_busy", bus.busy, 1);
    wait_done(n, 32'h0, 32'h0);
    chk("post_reset_latency", n, 32);
    chk("post_reset_hi", bus.HI, 32'h00000001);
    chk("post_reset_lo", bus.LO, 32'h00000003);
    $display("divu after reset -> HI=%h LO=%h lat=%0d", bus.HI, bus.LO, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
